// File: rtl/status_cs_scheduler.sv
// Purpose : time-slices CHANNELS active-low status chip selects round-robin over the opt enable mask.
// Latency : first chip select drops two edges after a nonzero opt is first seen in IDLE; slot SLOT_CYCLES, gap GUARD_CYCLES+1.
// Backpressure: none on the datapath; clearing opt[active_idx] truncates the slot, hold (STATUS_CS_HOLD_EN) stretches it.
//
// Ports:
//   clk, rst_n     single clock, asynchronous active-low reset
//   opt            per-channel enable mask (bit i enables channel i)
//   cs_n           registered active-low chip selects, at most one low
//   active_idx     registered index of the current / last selected channel
//   slot_start     one-cycle pulse on the first cycle a chip select is low
//   hold           only when STATUS_CS_HOLD_EN is defined: freezes the running slot
// Optional feature macro: STATUS_CS_HOLD_EN (undefined by default -> no hold port).

module status_cs_scheduler #(
    parameter int CHANNELS     = 2,
    parameter int SLOT_CYCLES  = 1024,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [CHANNELS-1:0]                            opt,
    output logic [CHANNELS-1:0]                            cs_n,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] active_idx,
    output logic                                           slot_start
`ifdef STATUS_CS_HOLD_EN
    ,
    input  logic                                           hold
`endif
);

    localparam int IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MAXC = (SLOT_CYCLES > GUARD_CYCLES) ? SLOT_CYCLES : GUARD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

    // Counters count down to zero; loading N-1 gives exactly N cycles in the state.
    localparam logic [CW-1:0] SLOT_LOAD  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_ACTIVE = 2'd2,
        S_GUARD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CHANNELS-1:0] cs_n_d;
    logic                slot_start_d;

    logic                pick_hi_vld;
    logic [IW-1:0]       pick_hi;
    logic [IW-1:0]       pick_lo;
    logic [IW-1:0]       pick_idx;
    logic                cur_en;
    logic                hold_req;

`ifdef STATUS_CS_HOLD_EN
    assign hold_req = hold;
`else
    assign hold_req = 1'b0;
`endif

    assign cur_en = opt[idx_q];

    // Round-robin pick: lowest enabled index above idx_q, otherwise wrap to the
    // lowest enabled index at or below it (which may be idx_q itself). Scanning
    // downwards lets the last hit in each half be the lowest one.
    always_comb begin
        pick_hi_vld = 1'b0;
        pick_hi     = '0;
        pick_lo     = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (opt[i]) begin
                if (i > int'(idx_q)) begin
                    pick_hi_vld = 1'b1;
                    pick_hi     = IW'(i);
                end else begin
                    pick_lo = IW'(i);
                end
            end
        end
        pick_idx = pick_hi_vld ? pick_hi : pick_lo;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        slot_start_d = 1'b0;
        cs_n_d       = '1;

        case (state_q)
            S_IDLE: begin
                if (|opt) begin
                    state_d = S_SELECT;
                    cnt_d   = '0;
                end
            end
            S_SELECT: begin
                if (!(|opt)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d      = S_ACTIVE;
                    idx_d        = pick_idx;
                    cnt_d        = SLOT_LOAD;
                    slot_start_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                // Losing the enable beats hold: the select is released next edge.
                if (!cur_en) begin
                    state_d = S_GUARD;
                    cnt_d   = GUARD_LOAD;
                end else if (hold_req) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = S_GUARD;
                    cnt_d   = GUARD_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = S_SELECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so cs_n tracks the state exactly.
        if (state_d == S_ACTIVE) begin
            cs_n_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= IW'(CHANNELS - 1);
            cs_n       <= '1;
            slot_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cs_n       <= cs_n_d;
            slot_start <= slot_start_d;
        end
    end

    assign active_idx = idx_q;

endmodule
